pc_sequencer: RTL

- Program-counter owner and control initiator for the next_address block.
- Fetches an instruction word and decodes its control fields.
- Drives every next_address input from registered state: flags, branch/jump fields, pc, selectors, return address.
- Loads the resulting incr_pc back into pc, closing the fetch loop between instruction memory and next_address.

---
 rtl/pc_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter owner: fetches, decodes control fields and drives
// next_address from registered state, then loads incr_pc back into pc.
// Ports: clk, rst_n (sync active-low); imem_req/instr_valid/instr fetch;
// flag_we/zero_in/carry_in/msb_in flags; incr_pc from next_address;
// pc, flags, branch_label, brtype, jmp_label, jmp_ra, counter_selector,
// halted outputs.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned NA_WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic        flag_we,
  input  logic        zero_in,
  input  logic        carry_in,
  input  logic        msb_in,
  input  logic [31:0] incr_pc,
  output logic [31:0] pc,
  output logic        zero_flag,
  output logic        carry_flag,
  output logic        msb,
  output logic [15:0] branch_label,
  output logic [2:0]  brtype,
  output logic [25:0] jmp_label,
  output logic [31:0] jmp_ra,
  output logic [1:0]  counter_selector,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  localparam logic [3:0] LAST = 4'(NA_WAIT - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] pc_q;
  logic [31:0] jmp_ra_q;
  logic        imem_req_q;
  logic        halted_q;
  logic        call_q;
  logic [2:0]  flags_q;
  logic [2:0]  pend_q;
  logic        pend_v_q;
  logic [15:0] br_lbl_q;
  logic [25:0] jmp_lbl_q;
  logic [2:0]  brtype_q;
  logic [1:0]  cs_q;

  logic [2:0]  op;
  logic [1:0]  cs_d;
  logic [2:0]  brtype_d;
  logic        call_d;
  logic        halt_d;
  logic        accept;
  logic        last;
  logic        flag_hold;

  assign op        = instr[31:29];
  assign accept    = (state_q == S_FETCH) && imem_req_q && instr_valid;
  assign last      = (state_q == S_EXEC) && (cnt_q == LAST);
  // Flags must stay stable while next_address is computing.
  assign flag_hold = (state_q == S_EXEC) && !last;

  always_comb begin
    cs_d     = 2'd0;
    brtype_d = 3'd0;
    call_d   = 1'b0;
    halt_d   = 1'b0;
    unique case (1'b1)
      !op[2]: ;
      op == 3'b100: brtype_d = instr[28:26];
      op == 3'b101: cs_d = 2'd1;
      op == 3'b110: begin
        cs_d   = 2'd1;
        call_d = 1'b1;
      end
      op == 3'b111 && !instr[28]: cs_d = 2'd2;
      op == 3'b111 && instr[28]: halt_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      cnt_q      <= 4'd0;
      pc_q       <= RESET_PC;
      jmp_ra_q   <= 32'd0;
      imem_req_q <= 1'b0;
      halted_q   <= 1'b0;
      call_q     <= 1'b0;
      flags_q    <= 3'd0;
      pend_q     <= 3'd0;
      pend_v_q   <= 1'b0;
      br_lbl_q   <= 16'd0;
      jmp_lbl_q  <= 26'd0;
      brtype_q   <= 3'd0;
      cs_q       <= 2'd0;
    end else begin
      if (flag_hold) begin
        if (flag_we) begin
          pend_q   <= {zero_in, carry_in, msb_in};
          pend_v_q <= 1'b1;
        end
      end else begin
        // A fresh write on the update edge supersedes a held one.
        if (flag_we)
          flags_q <= {zero_in, carry_in, msb_in};
        else if (pend_v_q)
          flags_q <= pend_q;
        pend_v_q <= 1'b0;
      end

      case (state_q)
        S_FETCH: begin
          imem_req_q <= !accept;
          if (accept) begin
            br_lbl_q  <= instr[15:0];
            jmp_lbl_q <= instr[25:0];
            brtype_q  <= brtype_d;
            cs_q      <= cs_d;
            call_q    <= call_d;
            cnt_q     <= 4'd0;
            halted_q  <= halt_d;
            state_q   <= halt_d ? S_HALT : S_EXEC;
          end
        end
        S_EXEC: begin
          imem_req_q <= 1'b0;
          cnt_q      <= cnt_q + 4'd1;
          if (last) begin
            pc_q    <= incr_pc;
            if (call_q)
              jmp_ra_q <= pc_q + 32'd1;
            call_q  <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        S_HALT: begin
          imem_req_q <= 1'b0;
          halted_q   <= 1'b1;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign imem_req         = imem_req_q;
  assign pc               = pc_q;
  assign zero_flag        = flags_q[2];
  assign carry_flag       = flags_q[1];
  assign msb              = flags_q[0];
  assign branch_label     = br_lbl_q;
  assign brtype           = brtype_q;
  assign jmp_label        = jmp_lbl_q;
  assign jmp_ra           = jmp_ra_q;
  assign counter_selector = cs_q;
  assign halted           = halted_q;

endmodule
